// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: shared types and constants for the SoC memory arbiter.
package soc_mem_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  localparam logic [31:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; on a tie the master not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       pick,
  output logic       any
);
  assign any  = |req;
  assign pick = &req ? ~last_grant : req[1];
endmodule

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: two-master round-robin arbiter onto one valid/ready memory bus.
// Define SOC_MEM_ARB_TIMEOUT_EN to build in the watchdog that aborts stalled transactions.
module soc_mem_arbiter
  import soc_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                grant,
  output logic                busy,
  output logic                timeout_err
);
  arb_state_t        r_state, w_next;
  logic              r_last_grant;
  logic              w_pick, w_any, w_own, w_sel, w_mvalid, w_to, w_done;
  logic [DATA_W-1:0] w_rdata;

  rr_arb2 u_rr (
    .req        ({m1_valid, m0_valid}),
    .last_grant (r_last_grant),
    .pick       (w_pick),
    .any        (w_any)
  );

  assign w_own    = r_state != IDLE;
  assign w_sel    = r_state == OWN1;
  assign w_mvalid = w_sel ? m1_valid : m0_valid;
  assign w_done   = w_own & w_mvalid & (s_ready | w_to);
  assign w_rdata  = s_ready ? s_rdata : DATA_W'(ARB_ERR_RDATA);

  assign busy     = w_own;
  assign grant    = w_sel;
  assign s_valid  = w_own & w_mvalid & ~w_to;
  assign s_addr   = !w_own ? '0 : w_sel ? m1_addr  : m0_addr;
  assign s_wdata  = !w_own ? '0 : w_sel ? m1_wdata : m0_wdata;
  assign s_wstrb  = !w_own ? '0 : w_sel ? m1_wstrb : m0_wstrb;
  assign m0_ready = w_done & ~w_sel;
  assign m1_ready = w_done & w_sel;
  assign m0_rdata = m0_ready ? w_rdata : '0;
  assign m1_rdata = m1_ready ? w_rdata : '0;

  // A dropped request while owned is an abort: back to IDLE without touching last_grant.
  always_comb begin
    w_next = !w_own ? (w_any ? (w_pick == M1 ? OWN1 : OWN0) : IDLE)
           : (!w_mvalid || w_done) ? IDLE : r_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= M1;
    end else begin
      r_state <= w_next;
      if (w_done) r_last_grant <= w_sel;
    end
  end

`ifdef SOC_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_terr;

  // s_ready has priority: the watchdog fires only in a cycle without completion.
  assign w_to        = w_own & w_mvalid & ~s_ready & (r_cnt == CW'(TIMEOUT_CYCLES));
  assign timeout_err = r_terr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else begin
      r_cnt <= (w_own && w_next != IDLE) ? r_cnt + 1'b1 : '0;
      if (w_to) r_terr <= 1'b1;
    end
  end
`else
  assign w_to        = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb_soc_mem_arbiter: directed table-driven bench for the two-master memory arbiter.
module tb_soc_mem_arbiter;
`ifdef SOC_MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  localparam logic [31:0] A0 = 32'h0000_0010, D0 = 32'h1111_2222;
  localparam logic [3:0]  W0 = 4'b0000;
  localparam logic [31:0] A1 = 32'h0200_0000, D1 = 32'hCAFE_F00D;
  localparam logic [3:0]  W1 = 4'b0011;

  logic        clk = 1'b0, reset = 1'b1;
  logic        m0_valid = 0, m1_valid = 0, m0_ready, m1_ready;
  logic [31:0] m0_addr = A0, m1_addr = A1, m0_wdata = D0, m1_wdata = D1;
  logic [3:0]  m0_wstrb = W0, m1_wstrb = W1;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata = 0;
  logic [3:0]  s_wstrb;
  logic        s_valid, s_ready = 0, grant, busy, timeout_err;
  int          n_chk = 0, n_fail = 0;

  soc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // st = {busy, grant, s_valid, m0_ready, m1_ready}
  typedef struct packed {
    logic        m0v, m1v, sr;
    logic [31:0] srd;
    logic [4:0]  st;
    logic [31:0] rd0, rd1;
  } vec_t;
  vec_t tv [14];

  task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [4:0] st_now();
    return {busy, grant, s_valid, m0_ready, m1_ready};
  endfunction

  initial begin
    logic [71:0] exp_fwd;
    int          own_sv;
    logic        got;
    logic [31:0] rd;
    logic        svp;
    tv[0]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 5'b00000, 32'h0, 32'h0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 32'hA1A1_A1A1, 5'b10110, 32'hA1A1_A1A1, 32'h0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'b00000, 32'h0, 32'h0};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 32'hB2B2_B2B2, 5'b11101, 32'h0, 32'hB2B2_B2B2};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 32'h7777_7777, 5'b00000, 32'h0, 32'h0};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 32'hC3C3_C3C3, 5'b10110, 32'hC3C3_C3C3, 32'h0};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 5'b00000, 32'h0, 32'h0};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 5'b11100, 32'h0, 32'h0};
    tv[8]  = '{1'b0, 1'b1, 1'b1, 32'h5A5A_5A5A, 5'b11101, 32'h0, 32'h5A5A_5A5A};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'b00000, 32'h0, 32'h0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'b10100, 32'h0, 32'h0};
    tv[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'b10100, 32'h0, 32'h0};
    tv[12] = '{1'b1, 1'b0, 1'b1, 32'h1234_5678, 5'b10110, 32'h1234_5678, 32'h0};
    tv[13] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'b00000, 32'h0, 32'h0};

    @(negedge clk);
    chk("reset_status", 72'(st_now()), 72'd0);
    chk("reset_rdata", {8'd0, m0_rdata, m1_rdata}, 72'd0);
    chk("reset_fwd", {s_addr, s_wdata, s_wstrb}, 72'd0);
    chk("reset_terr", 72'(timeout_err), 72'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      m0_valid = tv[i].m0v;
      m1_valid = tv[i].m1v;
      s_ready  = tv[i].sr;
      s_rdata  = tv[i].srd;
      @(negedge clk);
      exp_fwd = !tv[i].st[4] ? 72'd0 : tv[i].st[3] ? {A1, D1, W1} : {A0, D0, W0};
      chk($sformatf("row%0d_status", i), 72'(st_now()), 72'(tv[i].st));
      chk($sformatf("row%0d_rdata", i), {8'd0, m0_rdata, m1_rdata}, {8'd0, tv[i].rd0, tv[i].rd1});
      chk($sformatf("row%0d_fwd", i), {s_addr, s_wdata, s_wstrb}, exp_fwd);
      tick();
    end

    // reset while m0 is stalled; last_grant is 0 here so only a reset hands the tie to m0
    m0_valid = 1; s_ready = 0;
    @(negedge clk);
    chk("rst_pre_idle", 72'(st_now()), 72'd0);
    tick();
    @(negedge clk);
    chk("rst_pre_own", 72'(st_now()), 72'(5'b10100));
    reset = 1'b1;
    #1;
    chk("rst_async", 72'(st_now()), 72'd0);
    tick();
    reset = 1'b0;
    m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'hD4D4_D4D4;
    @(negedge clk);
    chk("rst_tie_idle", 72'(st_now()), 72'd0);
    tick();
    @(negedge clk);
    chk("rst_tie_m0", 72'(st_now()), 72'(5'b10110));
    chk("rst_tie_rd", 72'(m0_rdata), 72'(32'hD4D4_D4D4));
    tick();
    m0_valid = 0; m1_valid = 0; s_ready = 0;

    // m0 abandons its request mid-transaction
    m0_valid = 1;
    @(negedge clk);
    chk("abort_idle0", 72'(st_now()), 72'd0);
    tick();
    @(negedge clk);
    chk("abort_own", 72'(st_now()), 72'(5'b10100));
    tick();
    m0_valid = 0; m1_valid = 1;
    #1;
    chk("abort_drop", 72'(st_now()), 72'(5'b10000));
    tick();
    @(negedge clk);
    chk("abort_idle", 72'(st_now()), 72'd0);
    tick();
    s_ready = 1; s_rdata = 32'hE5E5_E5E5;
    @(negedge clk);
    chk("abort_m1", 72'(st_now()), 72'(5'b11101));
    chk("abort_m1_rd", {8'd0, m0_rdata, m1_rdata}, {40'd0, 32'hE5E5_E5E5});
    tick();
    m1_valid = 0; s_ready = 0;

`ifdef SOC_MEM_ARB_TIMEOUT_EN
    m0_valid = 1;
    @(negedge clk);
    chk("to_idle", 72'(st_now()), 72'd0);
    tick();
    own_sv = 0; got = 0; rd = 0; svp = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_ready) begin
        got = 1; rd = m0_rdata; svp = s_valid;
        break;
      end
      own_sv += int'(s_valid);
      tick();
    end
    chk("to_pulse", 72'(got), 72'd1);
    chk("to_own_cycles", 72'(own_sv), 72'(TO));
    chk("to_rdata", 72'(rd), 72'(32'hDEAD_BEEF));
    chk("to_svalid_low", 72'(svp), 72'd0);
    tick();
    m0_valid = 0; m1_valid = 1; s_ready = 1; s_rdata = 32'hF6F6_F6F6;
    @(negedge clk);
    chk("to_err_set", {70'd0, timeout_err, busy}, 72'(2'b10));
    tick();
    @(negedge clk);
    chk("to_m1_status", 72'(st_now()), 72'(5'b11101));
    chk("to_m1_rd", 72'(m1_rdata), 72'(32'hF6F6_F6F6));
    chk("to_err_sticky", 72'(timeout_err), 72'd1);
    tick();
    m1_valid = 0; s_ready = 0;
`else
    @(negedge clk);
    chk("terr_tied", 72'(timeout_err), 72'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/soc_mem_arbiter.md
# soc_mem_arbiter

Two-master round-robin arbiter sharing the SoC's single memory/peripheral bus between the CPU native memory port (master 0) and a second bus master such as a DMA or UART program loader (master 1). It sits between the masters and the SoC memory decoder, and uses the picorv32-style valid/ready native protocol on every port. Only one transaction is in flight at a time. An optional watchdog aborts transactions the slave never completes.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- TIMEOUT_CYCLES, 255, watchdog limit in clk cycles (used only with the watchdog compiled in)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- m0_valid / m1_valid  in  1  master request
- m0_ready / m1_ready  out  1  one-cycle completion pulse to master
- m0_addr / m1_addr  in  ADDR_W  request address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_wstrb / m1_wstrb  in  DATA_W/8  byte strobes; all zero means read
- m0_rdata / m1_rdata  out  DATA_W  read data, valid when the matching ready is high
- s_valid  out  1  request to slave
- s_ready  in  1  slave completion
- s_addr, s_wdata, s_wstrb  out  ADDR_W, DATA_W, DATA_W/8  forwarded request
- s_rdata  in  DATA_W  slave read data
- grant  out  1  index of the granted master; meaningful only while busy
- busy  out  1  a transaction is owned
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, OWN0, OWN1.
- **IDLE**
  - If exactly one mX_valid is high, go to OWNX.
  - If both are high, grant the master not served last. last_grant resets to 1, so m0 wins the first tie.
- **OWNX**
  - s_valid = mX_valid. s_addr, s_wdata and s_wstrb pass through combinationally from mX.
  - On s_ready: mX_ready = 1 for that cycle, mX_rdata = s_rdata, last_grant <= X, next state IDLE.
- **Abort:** if mX_valid drops while in OWNX before s_ready (a protocol violation), s_valid drops in the same cycle and the next state is IDLE. last_grant is unchanged.
- **Non-granted master:** ready = 0 and rdata = 0.
- **In IDLE:** s_valid = 0, and s_addr, s_wdata, s_wstrb = 0.
- busy = (state != IDLE). grant = 1 in OWN1, otherwise 0.
- The arbiter never modifies data; there is no width conversion.

## Timing
- **Reset values:** state IDLE, last_grant 1, all outputs 0, timeout_err 0. Reset mid-transaction drops s_valid and all ready outputs immediately (asynchronously).
- **Grant latency:** a request seen in IDLE at cycle 0 is registered at the edge ending cycle 0, so s_valid is high in cycle 1.
- **Completion:** s_ready in cycle N gives mX_ready in cycle N, combinationally. The FSM is in IDLE in cycle N+1.
- **Minimum cost:** 1 arbitration cycle plus the slave latency. Back-to-back transactions from alternating masters therefore complete at most once every 2 cycles.
- **Zero-wait slave:** a slave that raises s_ready in the first OWN cycle gives a 2-cycle transaction.
- **Simultaneous events:** a new request arriving in the same cycle as s_ready is only evaluated in the following IDLE cycle.

## Configuration
- **SOC_MEM_ARB_TIMEOUT_EN defined:**
  - A counter clears on entry to OWNX and increments every OWN cycle without s_ready.
  - When the count reaches TIMEOUT_CYCLES, the arbiter asserts mX_ready for one cycle with mX_rdata = 32'hDEAD_BEEF and forces s_valid to 0.
  - It then sets timeout_err, which stays set until reset, and goes to IDLE.
  - If s_ready and the timeout coincide, s_ready wins: normal completion, no error.
- **Not defined:** no counter; the arbiter waits indefinitely for s_ready. timeout_err is tied to 0.

## Structure
- **Package soc_mem_pkg:**
  - the arb_state_t enum (IDLE, OWN0, OWN1)
  - ARB_ERR_RDATA = 32'hDEAD_BEEF
  - the master-index constants M0 = 0 and M1 = 1
- **Sub-module rr_arb2:** a combinational two-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: pick and any.
  - Reused later for other shared resources.

## Test plan
- m0 read to 0x0000_0010 only; slave answers s_ready with 0x1234_5678 two cycles after s_valid -> m0_ready pulses once with that rdata; m1_ready stays 0; busy is high for 3 cycles.
- m0 and m1 both request from reset, zero-wait slave -> m0 is served first, m1 second; grant sequence 0, 1; the next simultaneous pair starts with m0 again.
- m1 write 0xCAFE_F00D to 0x0200_0000 with wstrb 4'b0011 -> s_addr, s_wdata and s_wstrb match exactly while s_valid is high; m1_ready pulses for 1 cycle.
- Reset asserted mid-OWN0, while the slave is stalled -> s_valid, m0_ready and busy go to 0 immediately; after release the first tie goes to m0.
- m0 drops valid in OWN0 before s_ready -> s_valid falls the same cycle; FSM is in IDLE next cycle; m1 is then granted normally.
- SOC_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never ready -> m0_ready pulses after 8 OWN cycles with rdata 0xDEAD_BEEF; timeout_err stays 1; a following m1 request completes normally.
